dense_layer_param: RTL and testbench

Parametrised fully-connected layer engine for the MNIST/CNN accelerator datapath, successor to the fixed-size dense stages. It holds IN_DIM×OUT_DIM signed weights and OUT_DIM biases in internal memory loaded over a host write port. It accepts an input activation vector over a valid/ready stream and computes each output with one multiply-accumulate per cycle. Each output is post-processed (optional ReLU, arithmetic right shift, saturation) and stored in an output buffer readable by the next stage or the SoC bus.

---
 rtl/dense_layer_param_if.sv | 51 +++++
 rtl/dense_layer_param.sv | 229 ++++++++++++++++++++++
 tb/tb_dense_layer_param.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_param_if.sv
//==============================================================================
// Module      : dense_layer_param_if
// Description : Host write, activation stream, control/status and readout
//               signals of the parametrised dense layer engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dense_layer_param_if #(
    parameter int IN_DIM  = 128,
    parameter int OUT_DIM = 10,
    parameter int DATA_W  = 8,
    parameter int W_W     = 8,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16
);
    localparam int WA_W = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1;
    localparam int BA_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    logic                     wt_we;
    logic [WA_W-1:0]          wt_addr;
    logic signed [W_W-1:0]    wt_data;
    logic                     bias_we;
    logic [BA_W-1:0]          bias_addr;
    logic signed [ACC_W-1:0]  bias_data;
    logic                     start;
    logic                     relu_en;
    logic [4:0]               shift;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     busy;
    logic                     done;
    logic                     sat_flag;
    logic [BA_W-1:0]          rd_addr;
    logic signed [OUT_W-1:0]  rd_data;

    modport master (
        output wt_we, wt_addr, wt_data, bias_we, bias_addr, bias_data,
        output start, relu_en, shift, in_valid, in_data, rd_addr,
        input  in_ready, busy, done, sat_flag, rd_data
    );

    modport slave (
        input  wt_we, wt_addr, wt_data, bias_we, bias_addr, bias_data,
        input  start, relu_en, shift, in_valid, in_data, rd_addr,
        output in_ready, busy, done, sat_flag, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/dense_layer_param.sv
//==============================================================================
// Module      : dense_layer_param
// Description : Fully-connected layer engine, one MAC per cycle, with ReLU,
//               arithmetic shift and saturation into a readable output buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dense_layer_param #(
    parameter int IN_DIM  = 128,
    parameter int OUT_DIM = 10,
    parameter int DATA_W  = 8,
    parameter int W_W     = 8,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    dense_layer_param_if.slave bus
);
    localparam int N_W    = IN_DIM * OUT_DIM;
    localparam int WA_W   = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int BA_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int IA_W   = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int WA_P1  = WA_W + 1;
    localparam int BA_P1  = BA_W + 1;
    localparam int PROD_W = DATA_W + W_W;

    localparam logic [IA_W-1:0]  c_I_LAST  = IA_W'(IN_DIM - 1);
    localparam logic [BA_W-1:0]  c_O_LAST  = BA_W'(OUT_DIM - 1);
    localparam logic [WA_W:0]    c_W_DEPTH = WA_P1'(N_W);
    localparam logic [BA_W:0]    c_O_DEPTH = BA_P1'(OUT_DIM);
    localparam logic signed [ACC_W-1:0] c_OUT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_OUT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage arrays carry no reset; only control and status registers do.
    logic signed [W_W-1:0]    r_wmem [N_W];
    logic signed [ACC_W-1:0]  r_bmem [OUT_DIM];
    logic signed [DATA_W-1:0] r_xmem [IN_DIM];
    logic signed [OUT_W-1:0]  r_obuf [OUT_DIM];

    logic [IA_W-1:0]          r_idx;
    logic [BA_W-1:0]          r_o;
    logic [WA_W-1:0]          r_waddr;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_relu;
    logic [4:0]               r_shift;
    logic                     r_sat;
    logic signed [OUT_W-1:0]  r_rd_data;

    logic                     w_in_ready;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_last_in;
    logic                     w_last_out;
    logic                     w_wt_addr_ok;
    logic                     w_bias_addr_ok;
    logic                     w_rd_addr_ok;
    logic [BA_W-1:0]          w_o_nxt;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_nxt;
    logic signed [ACC_W-1:0]  w_relu_v;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [ACC_W-1:0]  w_clamped;
    logic                     w_hi;
    logic                     w_lo;
    logic                     w_sat;
    logic signed [OUT_W-1:0]  w_post;

    assign w_last_in      = (r_idx == c_I_LAST);
    assign w_last_out     = (r_o == c_O_LAST);
    assign w_wt_addr_ok   = ({1'b0, bus.wt_addr} < c_W_DEPTH);
    assign w_bias_addr_ok = ({1'b0, bus.bias_addr} < c_O_DEPTH);
    assign w_rd_addr_ok   = ({1'b0, bus.rd_addr} < c_O_DEPTH);
    assign w_o_nxt        = r_o + BA_W'(1);

    // Weights are stored o-major, so one running address walks every row in turn.
    assign w_prod     = PROD_W'(r_wmem[r_waddr]) * PROD_W'(r_xmem[r_idx]);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_nxt = r_bmem[w_o_nxt];

    assign w_relu_v  = (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;
    assign w_shifted = w_relu_v >>> r_shift;
    assign w_hi      = (w_shifted > c_OUT_MAX);
    assign w_lo      = (w_shifted < c_OUT_MIN);
    assign w_sat     = w_hi | w_lo;
    assign w_clamped = w_hi ? c_OUT_MAX : (w_lo ? c_OUT_MIN : w_shifted);
    assign w_post    = w_clamped[OUT_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_last_in) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_last_in) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = w_last_out ? S_DONE : S_COMPUTE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx   <= '0;
            r_o     <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
            r_relu  <= 1'b0;
            r_shift <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_relu  <= bus.relu_en;
                        r_shift <= bus.shift;
                        r_sat   <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (w_last_in) begin
                            r_idx   <= '0;
                            r_o     <= '0;
                            r_waddr <= '0;
                            r_acc   <= r_bmem[0];
                        end else begin
                            r_idx <= r_idx + IA_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_waddr <= r_waddr + WA_W'(1);
                    r_idx   <= w_last_in ? '0 : r_idx + IA_W'(1);
                end
                S_WRITE: begin
                    r_sat <= r_sat | w_sat;
                    if (!w_last_out) begin
                        r_o   <= w_o_nxt;
                        r_acc <= w_bias_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A read racing the WRITE of the same entry sees the pre-write contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_addr_ok ? r_obuf[bus.rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.wt_we && w_wt_addr_ok) begin
            r_wmem[bus.wt_addr] <= bus.wt_data;
        end
        if (r_state == S_IDLE && bus.bias_we && w_bias_addr_ok) begin
            r_bmem[bus.bias_addr] <= bus.bias_data;
        end
        if (r_state == S_LOAD && bus.in_valid) begin
            r_xmem[r_idx] <= bus.in_data;
        end
        if (r_state == S_WRITE) begin
            r_obuf[r_o] <= w_post;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sat_flag = r_sat;
    assign bus.rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_dense_layer_param.sv
//==============================================================================
// Module      : tb_dense_layer_param
// Description : Self-checking bench for dense_layer_param (4 inputs, 3 outputs).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dense_layer_param;
    localparam int IN_DIM  = 4;
    localparam int OUT_DIM = 3;
    localparam int DATA_W  = 8;
    localparam int W_W     = 8;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 16;
    localparam int N_W     = IN_DIM * OUT_DIM;
    localparam int WA_W    = $clog2(N_W);
    localparam int BA_W    = $clog2(OUT_DIM);
    localparam int LAT     = OUT_DIM * (IN_DIM + 1);

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dense_layer_param_if #(
        .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W),
        .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) bus ();

    dense_layer_param #(
        .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W),
        .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        int w;
        int b[OUT_DIM];
        int x[IN_DIM];
        bit relu;
        int sh;
        int e[OUT_DIM];
        bit sat;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   m_w[N_W];
    int   m_b[OUT_DIM];
    int   m_ob[OUT_DIM];
    bit   m_sat;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_row(input int w, input int b0, input int b1, input int b2,
                           input int x0, input int x1, input int x2, input int x3,
                           input bit relu, input int sh,
                           input int e0, input int e1, input int e2, input bit sat);
        vec_t r;
        r.w = w;
        r.b[0] = b0; r.b[1] = b1; r.b[2] = b2;
        r.x[0] = x0; r.x[1] = x1; r.x[2] = x2; r.x[3] = x3;
        r.relu = relu; r.sh = sh;
        r.e[0] = e0; r.e[1] = e1; r.e[2] = e2;
        r.sat = sat;
        tbl.push_back(r);
    endtask

    // Reference: exact integer dot product, 32-bit wrap, floor division, clamp.
    function automatic void model_run(input int x[IN_DIM], input bit relu, input int sh);
        longint acc, v, d, q;
        m_sat = 1'b0;
        for (int o = 0; o < OUT_DIM; o++) begin
            acc = m_b[o];
            for (int i = 0; i < IN_DIM; i++) begin
                acc += longint'(m_w[o * IN_DIM + i]) * longint'(x[i]);
            end
            acc = longint'(int'(acc));
            v = (relu && acc < 0) ? 0 : acc;
            d = longint'(1) << sh;
            q = v / d;
            if ((v % d) != 0 && v < 0) q = q - 1;
            if (q > 32767) begin
                q = 32767; m_sat = 1'b1;
            end else if (q < -32768) begin
                q = -32768; m_sat = 1'b1;
            end
            m_ob[o] = int'(q);
        end
    endfunction

    task automatic wr_w(input int a, input int v);
        bus.wt_we = 1'b1; bus.wt_addr = WA_W'(a); bus.wt_data = W_W'(v);
        tick();
        bus.wt_we = 1'b0;
        m_w[a] = v;
    endtask

    task automatic wr_b(input int a, input int v);
        bus.bias_we = 1'b1; bus.bias_addr = BA_W'(a); bus.bias_data = v;
        tick();
        bus.bias_we = 1'b0;
        m_b[a] = v;
    endtask

    task automatic readout(input int exp[OUT_DIM], input string tag);
        for (int a = 0; a <= OUT_DIM; a++) begin
            bus.rd_addr = BA_W'(a);
            tick();
            check($sformatf("%s_rd%0d", tag, a), bus.rd_data, (a < OUT_DIM) ? exp[a] : 0);
        end
    endtask

    // poke: start, weight write and stray in_valid while computing.
    // abort_at >= 0: pull resetn low that many cycles after the last input.
    task automatic do_run(input int x[IN_DIM], input bit relu, input int sh,
                          input bit gaps, input bit poke, input int abort_at,
                          input bit exp_sat, input string tag);
        int idx, cyc, k;
        bit fire, seen;
        bus.start = 1'b1; bus.relu_en = relu; bus.shift = 5'(sh);
        tick();
        bus.start = 1'b0; bus.relu_en = ~relu; bus.shift = ~5'(sh);
        check({tag, "_busy"}, bus.busy, 1);
        idx = 0; cyc = 0;
        while (idx < IN_DIM && cyc < 200) begin
            bus.in_valid = gaps ? ((cyc % 3) == 0) : 1'b1;
            bus.in_data  = bus.in_valid ? DATA_W'(x[idx]) : 8'h5A;
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (fire) idx++;
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (idx < IN_DIM) begin
            check({tag, "_load_timeout"}, idx, IN_DIM);
            return;
        end
        k = 0; seen = 1'b0;
        while (!seen && k < 200) begin
            if (k == abort_at) begin
                check({tag, "_busy_pre_reset"}, bus.busy, 1);
                #2 resetn = 1'b0;
                #1;
                check({tag, "_rst_in_ready"}, bus.in_ready, 0);
                check({tag, "_rst_busy"}, bus.busy, 0);
                check({tag, "_rst_done"}, bus.done, 0);
                check({tag, "_rst_sat"}, bus.sat_flag, 0);
                check({tag, "_rst_rd_data"}, bus.rd_data, 0);
                resetn = 1'b1;
                tick();
                return;
            end
            if (poke && k == 2) begin
                bus.start = 1'b1; bus.wt_we = 1'b1; bus.wt_addr = '0; bus.wt_data = 8'h55;
                bus.in_valid = 1'b1; bus.in_data = 8'h7F;
            end
            if (poke && k == 3) begin
                bus.start = 1'b0; bus.wt_we = 1'b0; bus.in_valid = 1'b0;
            end
            tick();
            k++;
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done_latency"}, k, LAT);
        check({tag, "_sat"}, bus.sat_flag, exp_sat);
        tick();
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int xs[IN_DIM];
        int n;
        bus.wt_we = 0; bus.wt_addr = '0; bus.wt_data = '0;
        bus.bias_we = 0; bus.bias_addr = '0; bus.bias_data = '0;
        bus.start = 0; bus.relu_en = 0; bus.shift = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.rd_addr = '0;

        @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_sat", bus.sat_flag, 0);
        check("reset_rd_data", bus.rd_data, 0);
        resetn = 1'b1;
        tick();

        //       w    b0 b1 b2   x0  x1  x2  x3 relu sh  e0     e1     e2   sat
        add_row( 1,   0, 5, 7,   1,  2,  3,  4, 0, 0,  10,    15,    17,    0);
        add_row(-1,   0, 0, 0,   1,  2,  3,  4, 0, 0, -10,   -10,   -10,    0);
        add_row(-1,   0, 0, 0,   1,  2,  3,  4, 1, 0,   0,     0,     0,    0);
        add_row(-1,   0, 0, 0,   1,  2,  3,  4, 0, 2,  -3,    -3,    -3,    0);
        add_row(127,  0, 0, 0, 127,127,127,127, 0, 0, 32767, 32767, 32767,  1);
        add_row(127,  0, 0, 0, 127,127,127,127, 0, 2, 16129, 16129, 16129,  0);

        n = 0;
        foreach (tbl[r]) begin
            for (int a = 0; a < N_W; a++) wr_w(a, tbl[r].w);
            for (int a = 0; a < OUT_DIM; a++) wr_b(a, tbl[r].b[a]);
            do_run(tbl[r].x, tbl[r].relu, tbl[r].sh, 0, 0, -1, tbl[r].sat,
                   $sformatf("vec%0d", n));
            readout(tbl[r].e, $sformatf("vec%0d", n));
            n++;
        end

        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < N_W; a++) wr_w(a, int'($urandom_range(0, 255)) - 128);
            for (int a = 0; a < OUT_DIM; a++)
                wr_b(a, (t % 2 == 1) ? int'($urandom()) : int'($urandom_range(0, 60000)) - 30000);
            for (int i = 0; i < IN_DIM; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
            model_run(xs, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
            begin
                bit rl;
                int sh;
                rl = 1'($urandom_range(0, 1));
                sh = int'($urandom_range(0, 12));
                model_run(xs, rl, sh);
                do_run(xs, rl, sh, 0, 0, -1, m_sat, $sformatf("rnd%0d", t));
            end
            readout(m_ob, $sformatf("rnd%0d", t));
        end

        // Backpressure: valid beats only every third cycle.
        for (int i = 0; i < IN_DIM; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
        model_run(xs, 0, 1);
        do_run(xs, 0, 1, 1, 0, -1, m_sat, "gaps");
        readout(m_ob, "gaps");

        // Start, weight write and in_valid during COMPUTE must all be ignored.
        wr_w(0, -7);
        xs[0] = 5; xs[1] = -3; xs[2] = 9; xs[3] = 2;
        model_run(xs, 0, 0);
        do_run(xs, 0, 0, 0, 1, -1, m_sat, "poke");
        readout(m_ob, "poke");
        xs[0] = 11; xs[1] = 4; xs[2] = -6; xs[3] = 1;
        model_run(xs, 0, 0);
        do_run(xs, 0, 0, 0, 0, -1, m_sat, "after_poke");
        readout(m_ob, "after_poke");

        // Reset mid-COMPUTE, then a clean rerun with memories intact.
        bus.rd_addr = '0;
        tick();
        do_run(xs, 0, 0, 0, 0, 2, 0, "abort");
        xs[0] = -8; xs[1] = 13; xs[2] = 7; xs[3] = -2;
        model_run(xs, 1, 0);
        do_run(xs, 1, 0, 0, 0, -1, m_sat, "post_reset");
        readout(m_ob, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
